// File: rtl/uart_frame_sampler.sv
`default_nettype none
// ============================================================================
// uart_frame_sampler : oversampled UART receive framer with majority voting
// Revision 1.0
// ============================================================================
module uart_frame_sampler #(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 8,
  parameter int MAJORITY      = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tick_os,
  input  logic                               rx_filtered,
  input  logic                               rx_en,
  input  logic [$clog2(MAX_DATA_BITS+1)-1:0] cfg_data_bits,
  input  logic                               cfg_parity_en,
  input  logic                               cfg_parity_odd,
  input  logic                               cfg_stop2,
  output logic [MAX_DATA_BITS-1:0]           rx_data,
  output logic                               rx_valid,
  output logic                               parity_err,
  output logic                               frame_err,
  output logic                               noise_err,
  output logic                               start_detected,
  output logic                               busy
);

  localparam int c_cw  = $clog2(OVERSAMPLE);
  localparam int c_dbw = $clog2(MAX_DATA_BITS + 1);
  localparam logic [c_cw-1:0]  c_dec      = c_cw'(OVERSAMPLE / 2 - 1 + MAJORITY);
  localparam logic [c_cw-1:0]  c_last     = c_cw'(OVERSAMPLE - 1);
  localparam logic [c_dbw-1:0] c_max_bits = c_dbw'(MAX_DATA_BITS);
  localparam logic [c_dbw-1:0] c_min_bits = c_dbw'(5);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [c_cw-1:0]          cnt_q, cnt_d;
  logic                     line_q, line_d;
  logic [c_dbw-1:0]         bit_idx_q, bit_idx_d;
  logic [c_dbw-1:0]         nbits_q, nbits_d;
  logic                     par_en_q, par_en_d;
  logic                     par_odd_q, par_odd_d;
  logic                     stop2_q, stop2_d;
  logic                     stop_idx_q, stop_idx_d;
  logic [MAX_DATA_BITS-1:0] data_q, data_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     noise_q, noise_d;
  logic [MAX_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                     perr_out_q, perr_out_d;
  logic                     ferr_out_q, ferr_out_d;
  logic                     noise_out_q, noise_out_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     start_det_q, start_det_d;

  logic                     w_dec_tick;
  logic                     w_wrap;
  logic                     w_dec_bit;
  logic                     w_dec_noise;
  logic                     w_start_edge;
  logic [c_dbw-1:0]         w_cfg_bits;

  assign w_dec_tick   = tick_os && (cnt_q == c_dec);
  assign w_wrap       = tick_os && (cnt_q == c_last);
  assign w_start_edge = tick_os && rx_en && line_q && !rx_filtered;
  assign w_cfg_bits   = ((cfg_data_bits < c_min_bits) || (cfg_data_bits > c_max_bits))
                        ? c_max_bits : cfg_data_bits;

  // The third vote sample coincides with the decision tick, so it comes straight from the line.
  generate
    if (MAJORITY != 0) begin : g_vote
      localparam logic [c_cw-1:0] c_mid    = c_cw'(OVERSAMPLE / 2 - 1);
      localparam logic [c_cw-1:0] c_mid_m1 = c_cw'(OVERSAMPLE / 2 - 2);
      logic s0_q, s1_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s0_q <= 1'b1;
          s1_q <= 1'b1;
        end else if (tick_os) begin
          if (cnt_q == c_mid_m1) s0_q <= rx_filtered;
          if (cnt_q == c_mid)    s1_q <= rx_filtered;
        end
      end

      assign w_dec_bit   = (s0_q & s1_q) | (s0_q & rx_filtered) | (s1_q & rx_filtered);
      assign w_dec_noise = !((s0_q == s1_q) && (s1_q == rx_filtered));
    end else begin : g_single
      assign w_dec_bit   = rx_filtered;
      assign w_dec_noise = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = tick_os ? rx_filtered : line_q;
    bit_idx_d   = bit_idx_q;
    nbits_d     = nbits_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    stop2_d     = stop2_q;
    stop_idx_d  = stop_idx_q;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    noise_d     = noise_q;
    rx_data_d   = rx_data_q;
    perr_out_d  = perr_out_q;
    ferr_out_d  = ferr_out_q;
    noise_out_d = noise_out_q;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;

    if (state_q != S_IDLE) begin
      if (tick_os) cnt_d = w_wrap ? '0 : cnt_q + c_cw'(1);
      if (w_dec_tick && w_dec_noise) noise_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_start_edge) begin
          state_d    = S_START;
          cnt_d      = c_cw'(1);
          nbits_d    = w_cfg_bits;
          par_en_d   = cfg_parity_en;
          par_odd_d  = cfg_parity_odd;
          stop2_d    = cfg_stop2;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          data_d     = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          noise_d    = 1'b0;
        end
      end
      S_START: begin
        if (w_dec_tick) begin
          if (w_dec_bit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            start_det_d = 1'b1;
          end
        end
        if (w_wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (w_dec_tick) begin
          for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (bit_idx_q == c_dbw'(i)) data_d[i] = w_dec_bit;
          end
        end
        if (w_wrap) begin
          if (bit_idx_q == nbits_q - c_dbw'(1)) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + c_dbw'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_dec_tick) perr_d = (^data_q ^ w_dec_bit) != par_odd_q;
        if (w_wrap)     state_d = S_STOP;
      end
      S_STOP: begin
        if (w_dec_tick) begin
          if (!w_dec_bit) ferr_d = 1'b1;
          // Finishing at the decision tick leaves room for a back-to-back start bit.
          if (stop_idx_q == stop2_q) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            line_d      = w_dec_bit;
            rx_valid_d  = 1'b1;
            rx_data_d   = data_q;
            perr_out_d  = par_en_q & perr_q;
            ferr_out_d  = ferr_q | !w_dec_bit;
            noise_out_d = noise_q | w_dec_noise;
          end
        end
        if (w_wrap) stop_idx_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!rx_en) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      line_d      = tick_os ? rx_filtered : line_q;
      rx_valid_d  = 1'b0;
      start_det_d = 1'b0;
      rx_data_d   = rx_data_q;
      perr_out_d  = perr_out_q;
      ferr_out_d  = ferr_out_q;
      noise_out_d = noise_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      line_q      <= 1'b1;
      bit_idx_q   <= '0;
      nbits_q     <= c_max_bits;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      stop2_q     <= 1'b0;
      stop_idx_q  <= 1'b0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      noise_q     <= 1'b0;
      rx_data_q   <= '0;
      perr_out_q  <= 1'b0;
      ferr_out_q  <= 1'b0;
      noise_out_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      bit_idx_q   <= bit_idx_d;
      nbits_q     <= nbits_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      stop2_q     <= stop2_d;
      stop_idx_q  <= stop_idx_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      noise_q     <= noise_d;
      rx_data_q   <= rx_data_d;
      perr_out_q  <= perr_out_d;
      ferr_out_q  <= ferr_out_d;
      noise_out_q <= noise_out_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
    end
  end

  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign parity_err     = perr_out_q;
  assign frame_err      = ferr_out_q;
  assign noise_err      = noise_out_q;
  assign start_detected = start_det_q;
  assign busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire
